// File: rtl/axi4_burst_traffic_gen.sv
// AXI4 master that writes a seeded pattern over an address range in 4KB-safe INCR bursts,
// reads it back and counts mismatches. Define AXI_TG_ERR_LOG_EN to add first-error capture.
module axi4_burst_traffic_gen #(
   parameter int unsigned DATA_WIDTH    = 128,
   parameter int unsigned ADDR_WIDTH    = 40,
   parameter int unsigned MAX_BURST_LEN = 16,
   parameter logic [31:0] PATTERN_SEED  = 32'hA5A5_0000
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [15:0]           num_beats,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           err_count,
`ifdef AXI_TG_ERR_LOG_EN
   output logic                  first_err_valid,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
`endif
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [7:0]            awlen,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [7:0]            arlen,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready
);

   localparam int unsigned BYTES     = DATA_WIDTH / 8;
   localparam int unsigned LANES     = DATA_WIDTH / 32;
   localparam int unsigned SIZE_LOG2 = $clog2(BYTES);
   localparam logic [16:0] MAX_LEN   = 17'(MAX_BURST_LEN);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SIZE_LOG2;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_AW   = 3'd1;
   localparam logic [2:0] ST_W    = 3'd2;
   localparam logic [2:0] ST_B    = 3'd3;
   localparam logic [2:0] ST_AR   = 3'd4;
   localparam logic [2:0] ST_R    = 3'd5;
   localparam logic [2:0] ST_DONE = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           total_q, total_d;
   logic [15:0]           remaining_q, remaining_d;
   logic [15:0]           beat_n_q, beat_n_d;
   logic [8:0]            beat_idx_q, beat_idx_d;
   logic [15:0]           err_q, err_d;

   logic [8:0]            cur_beats;
   logic                  last_beat;
   logic [ADDR_WIDTH-1:0] addr_step;
   logic [15:0]           rem_after;
   logic [DATA_WIDTH-1:0] exp_data;
   logic                  r_bad;
   logic                  err_event;

   // Beats in the next burst: limited by what is left, the burst cap and the 4KB page end.
   function automatic logic [8:0] calc_beats(input logic [11:0] page_off, input logic [15:0] rem);
      logic [12:0] to_bound;
      logic [16:0] beats;
      to_bound = (13'h1000 - {1'b0, page_off}) >> SIZE_LOG2;
      beats    = {1'b0, rem};
      if (MAX_LEN < beats) beats = MAX_LEN;
      if ({4'b0, to_bound} < beats) beats = {4'b0, to_bound};
      return 9'(beats);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] pattern(input logic [15:0] n);
      logic [DATA_WIDTH-1:0] d;
      logic [31:0]           first;
      first = PATTERN_SEED + 32'(n) * 32'(LANES);
      for (int unsigned i = 0; i < LANES; i++) begin
         d[i*32 +: 32] = first + 32'(i);
      end
      return d;
   endfunction

   assign cur_beats = calc_beats(addr_q[11:0], remaining_q);
   assign last_beat = (beat_idx_q == cur_beats - 9'd1);
   assign addr_step = ADDR_WIDTH'(cur_beats) << SIZE_LOG2;
   assign rem_after = remaining_q - 16'(cur_beats);
   assign exp_data  = pattern(beat_n_q);
   assign r_bad     = (rresp != 2'b00) || (rdata != exp_data) || (rlast != last_beat);

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      addr_d      = addr_q;
      total_d     = total_q;
      remaining_d = remaining_q;
      beat_n_d    = beat_n_q;
      beat_idx_d  = beat_idx_q;
      err_d       = err_q;
      err_event   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d      = base_addr & ALIGN_MASK;
               addr_d      = base_addr & ALIGN_MASK;
               total_d     = num_beats;
               remaining_d = num_beats;
               beat_n_d    = 16'd0;
               beat_idx_d  = 9'd0;
               err_d       = 16'd0;
               state_d     = (num_beats == 16'd0) ? ST_DONE : ST_AW;
            end
         end
         ST_AW: begin
            if (awready) state_d = ST_W;
         end
         ST_W: begin
            if (wready) begin
               beat_n_d = beat_n_q + 16'd1;
               if (last_beat) begin
                  beat_idx_d = 9'd0;
                  state_d    = ST_B;
               end else begin
                  beat_idx_d = beat_idx_q + 9'd1;
               end
            end
         end
         ST_B: begin
            if (bvalid) begin
               err_event = (bresp != 2'b00);
               if (rem_after == 16'd0) begin
                  // Write phase finished: rewind to the start of the range for the read-back.
                  addr_d      = base_q;
                  remaining_d = total_q;
                  beat_n_d    = 16'd0;
                  state_d     = ST_AR;
               end else begin
                  addr_d      = addr_q + addr_step;
                  remaining_d = rem_after;
                  state_d     = ST_AW;
               end
            end
         end
         ST_AR: begin
            if (arready) state_d = ST_R;
         end
         ST_R: begin
            if (rvalid) begin
               err_event = r_bad;
               beat_n_d  = beat_n_q + 16'd1;
               // Burst end is tracked by our own count; a wrong rlast is only scored as an error.
               if (last_beat) begin
                  beat_idx_d  = 9'd0;
                  addr_d      = addr_q + addr_step;
                  remaining_d = rem_after;
                  state_d     = (rem_after == 16'd0) ? ST_DONE : ST_AR;
               end else begin
                  beat_idx_d = beat_idx_q + 9'd1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (err_event && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         addr_q      <= '0;
         total_q     <= 16'd0;
         remaining_q <= 16'd0;
         beat_n_q    <= 16'd0;
         beat_idx_q  <= 9'd0;
         err_q       <= 16'd0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         addr_q      <= addr_d;
         total_q     <= total_d;
         remaining_q <= remaining_d;
         beat_n_q    <= beat_n_d;
         beat_idx_q  <= beat_idx_d;
         err_q       <= err_d;
      end
   end

`ifdef AXI_TG_ERR_LOG_EN
   logic                  flog_valid_q;
   logic [ADDR_WIDTH-1:0] flog_addr_q;
   logic [ADDR_WIDTH-1:0] event_addr;

   // B errors report the burst address; R errors report the failing beat's own address.
   assign event_addr = (state_q == ST_R) ? addr_q + (ADDR_WIDTH'(beat_idx_q) << SIZE_LOG2)
                                         : addr_q;

   always_ff @(posedge aclk) begin
      if (areset) begin
         flog_valid_q <= 1'b0;
         flog_addr_q  <= '0;
      end else if ((state_q == ST_IDLE) && start) begin
         flog_valid_q <= 1'b0;
         flog_addr_q  <= '0;
      end else if (err_event && !flog_valid_q) begin
         flog_valid_q <= 1'b1;
         flog_addr_q  <= event_addr;
      end
   end

   assign first_err_valid = flog_valid_q;
   assign first_err_addr  = flog_addr_q;
`endif

   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign err_count = err_q;

   assign awvalid = (state_q == ST_AW);
   assign awaddr  = awvalid ? addr_q : '0;
   assign awlen   = awvalid ? 8'(cur_beats - 9'd1) : 8'd0;
   assign wvalid  = (state_q == ST_W);
   assign wdata   = wvalid ? exp_data : '0;
   assign wlast   = wvalid && last_beat;
   assign bready  = (state_q == ST_B);
   assign arvalid = (state_q == ST_AR);
   assign araddr  = arvalid ? addr_q : '0;
   assign arlen   = arvalid ? 8'(cur_beats - 9'd1) : 8'd0;
   assign rready  = (state_q == ST_R);

endmodule

// File: tb/tb_axi4_burst_traffic_gen.sv
// Bench for axi4_burst_traffic_gen: reactive memory slave with stalls and fault injection,
// burst/pattern reference model, table-driven runs plus random runs and a mid-run reset.
module tb_axi4_burst_traffic_gen;
   localparam int DW    = 128;
   localparam int AW    = 40;
   localparam int MBL   = 16;
   localparam int BYTES = DW / 8;
   localparam int LANES = DW / 32;
   localparam logic [31:0] SEED = 32'hA5A5_0000;

   logic          aclk = 1'b0;
   logic          areset, start;
   logic [AW-1:0] base_addr;
   logic [15:0]   num_beats;
   logic          busy, done;
   logic [15:0]   err_count;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [1:0]    bresp, rresp;
`ifdef AXI_TG_ERR_LOG_EN
   logic          first_err_valid;
   logic [AW-1:0] first_err_addr;
`endif

   axi4_burst_traffic_gen #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST_LEN(MBL), .PATTERN_SEED(SEED)
   ) dut (
      .aclk(aclk), .areset(areset), .start(start), .base_addr(base_addr),
      .num_beats(num_beats), .busy(busy), .done(done), .err_count(err_count),
`ifdef AXI_TG_ERR_LOG_EN
      .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
`endif
      .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Slave controls, logs and state.
   bit            stall_en;
   int            inj_b, inj_r, inj_l;
   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [AW-1:0] wr_addr_log[$], rd_addr_log[$];
   int            wr_len_log[$], rd_len_log[$];
   logic [DW-1:0] wdata_log[$];
   bit            wlast_log[$];
   logic [AW-1:0] w_addr, r_addr, aw_prev_addr, ar_prev_addr;
   logic [7:0]    aw_prev_len, ar_prev_len;
   logic [DW-1:0] w_prev_data;
   bit            w_prev_last, aw_hold, w_hold, ar_hold, r_active;
   int            b_pending, b_count, r_len, r_beat, rd_global;

   // Reference model of one run.
   logic [AW-1:0] exp_addr[$];
   int            exp_len[$];
   bit            exp_last[$];

   function automatic void build_model(input logic [AW-1:0] base, input int n);
      logic [AW-1:0] a;
      int rem, b, to4k;
      exp_addr.delete(); exp_len.delete(); exp_last.delete();
      a   = base & ~AW'(BYTES - 1);
      rem = n;
      while (rem > 0) begin
         to4k = (4096 - int'(a % 4096)) / BYTES;
         b = rem;
         if (b > MBL) b = MBL;
         if (b > to4k) b = to4k;
         exp_addr.push_back(a);
         exp_len.push_back(b);
         for (int i = 0; i < b; i++) exp_last.push_back(i == b - 1);
         a   = a + AW'(b * BYTES);
         rem = rem - b;
      end
   endfunction

   function automatic logic [DW-1:0] exp_beat(input int n);
      logic [DW-1:0] d;
      for (int i = 0; i < LANES; i++) d[i*32 +: 32] = SEED + 32'(n * LANES + i);
      return d;
   endfunction

   task automatic slave_clear();
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
      aw_hold = 0; w_hold = 0; ar_hold = 0; r_active = 0;
      b_pending = 0; r_beat = 0; r_len = 0;
   endtask

   // Slave acts on the falling edge; a handshake seen here completes on the next rising edge.
   initial begin
      slave_clear();
      forever begin
         @(negedge aclk);
         if (areset) begin
            slave_clear();
         end else begin
            bvalid = (b_pending > 0);
            bresp  = (bvalid && (b_count + 1 == inj_b)) ? 2'b10 : 2'b00;
            if (bvalid && bready) begin
               b_pending--;
               b_count++;
            end

            rvalid = r_active && (!stall_en || ($urandom_range(0, 3) != 0));
            rresp  = 2'b00;
            if (rvalid) begin
               rdata = mem.exists(r_addr) ? mem[r_addr] : '0;
               if (rd_global == inj_r) rdata[0] = ~rdata[0];
               rlast = (r_beat == r_len) ^ (rd_global == inj_l);
               if (rready) begin
                  r_addr = r_addr + AW'(BYTES);
                  rd_global++;
                  if (r_beat == r_len) r_active = 0;
                  else r_beat++;
               end
            end else begin
               rdata = '0;
               rlast = 0;
            end

            arready = !stall_en || ($urandom_range(0, 2) != 0);
            if (arvalid) begin
               if (ar_hold) begin
                  chk("ar stable addr", araddr, ar_prev_addr);
                  chk("ar stable len", arlen, ar_prev_len);
               end
               if (arready) begin
                  rd_addr_log.push_back(araddr);
                  rd_len_log.push_back(int'(arlen) + 1);
                  r_addr = araddr; r_len = int'(arlen); r_beat = 0; r_active = 1;
                  ar_hold = 0;
               end else begin
                  ar_hold = 1; ar_prev_addr = araddr; ar_prev_len = arlen;
               end
            end else ar_hold = 0;

            wready = !stall_en || ($urandom_range(0, 2) != 0);
            if (wvalid) begin
               if (w_hold) begin
                  chk("w stable data", wdata, w_prev_data);
                  chk("w stable last", wlast, w_prev_last);
               end
               if (wready) begin
                  mem[w_addr] = wdata;
                  wdata_log.push_back(wdata);
                  wlast_log.push_back(wlast);
                  w_addr = w_addr + AW'(BYTES);
                  if (wlast) b_pending++;
                  w_hold = 0;
               end else begin
                  w_hold = 1; w_prev_data = wdata; w_prev_last = wlast;
               end
            end else w_hold = 0;

            awready = !stall_en || ($urandom_range(0, 2) != 0);
            if (awvalid) begin
               if (aw_hold) begin
                  chk("aw stable addr", awaddr, aw_prev_addr);
                  chk("aw stable len", awlen, aw_prev_len);
               end
               if (awready) begin
                  wr_addr_log.push_back(awaddr);
                  wr_len_log.push_back(int'(awlen) + 1);
                  w_addr = awaddr;
                  aw_hold = 0;
               end else begin
                  aw_hold = 1; aw_prev_addr = awaddr; aw_prev_len = awlen;
               end
            end else aw_hold = 0;
         end
      end
   end

   task automatic clear_logs();
      wr_addr_log.delete(); wr_len_log.delete(); rd_addr_log.delete(); rd_len_log.delete();
      wdata_log.delete(); wlast_log.delete();
      b_count = 0; rd_global = 0;
   endtask

   task automatic run_test(input string name, input logic [AW-1:0] base, input int n,
                           input bit st, input int ib, input int ir, input int il,
                           input int exp_err, input logic [AW-1:0] exp_first, input bit poke);
      int  cyc, dones;
      bit  seen;
      stall_en = st; inj_b = ib; inj_r = ir; inj_l = il;
      clear_logs();
      build_model(base, n);
      base_addr = base; num_beats = 16'(n); start = 1;
      @(posedge aclk); #1;
      start = 0;
      if (n > 0) chk($sformatf("%s busy after start", name), busy, 1'b1);
      cyc = 0; dones = 0; seen = 0;
      while (!seen && cyc < 20000) begin
         if (done) begin
            seen = 1;
            dones++;
         end else begin
            if (poke && cyc == 5 && busy) begin
               start = 1; base_addr = base + 40'h40000; num_beats = 16'd3;
            end else start = 0;
            @(posedge aclk); #1;
            cyc++;
         end
      end
      start = 0;
      chk($sformatf("%s done reached", name), seen, 1'b1);
      chk($sformatf("%s busy low with done", name), busy, 1'b0);
      repeat (3) begin
         @(posedge aclk); #1;
         if (done) dones++;
      end
      chk($sformatf("%s done pulses", name), dones, 1);
      chk($sformatf("%s err_count", name), err_count, exp_err);
      chk($sformatf("%s aw bursts", name), wr_addr_log.size(), exp_addr.size());
      chk($sformatf("%s ar bursts", name), rd_addr_log.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (i < wr_addr_log.size()) begin
            chk($sformatf("%s awaddr[%0d]", name, i), wr_addr_log[i], exp_addr[i]);
            chk($sformatf("%s awlen+1[%0d]", name, i), wr_len_log[i], exp_len[i]);
         end
         if (i < rd_addr_log.size()) begin
            chk($sformatf("%s araddr[%0d]", name, i), rd_addr_log[i], exp_addr[i]);
            chk($sformatf("%s arlen+1[%0d]", name, i), rd_len_log[i], exp_len[i]);
         end
      end
      chk($sformatf("%s write beats", name), wdata_log.size(), n);
      for (int i = 0; i < n && i < wdata_log.size(); i++) begin
         chk($sformatf("%s wdata[%0d]", name, i), wdata_log[i], exp_beat(i));
         chk($sformatf("%s wlast[%0d]", name, i), wlast_log[i], exp_last[i]);
      end
`ifdef AXI_TG_ERR_LOG_EN
      chk($sformatf("%s first_err_valid", name), first_err_valid, exp_err != 0);
      if (exp_err != 0) chk($sformatf("%s first_err_addr", name), first_err_addr, exp_first);
`endif
   endtask

   typedef struct {
      string         name;
      logic [AW-1:0] base;
      int            n;
      bit            st;
      int            ib, ir, il;
      int            exp_err;
      logic [AW-1:0] first;
      bit            poke;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int cyc;
      vecs[0]  = '{"single8",   40'h1000,           8, 0, 0, -1, -1, 0, 40'h0,    0};
      vecs[1]  = '{"split4k",   40'h0FC0,          16, 0, 0, -1, -1, 0, 40'h0,    0};
      vecs[2]  = '{"max40",     40'h2000,          40, 0, 0, -1, -1, 0, 40'h0,    0};
      vecs[3]  = '{"errs",      40'h1000,          40, 0, 2,  5, -1, 2, 40'h1100, 0};
      vecs[4]  = '{"stall",     40'h7FA0,          37, 1, 0, -1, -1, 0, 40'h0,    1};
      vecs[5]  = '{"empty",     40'h4000,           0, 0, 0, -1, -1, 0, 40'h0,    0};
      vecs[6]  = '{"unaligned", 40'h300F,           5, 0, 0, -1, -1, 0, 40'h0,    0};
      vecs[7]  = '{"rdcorrupt", 40'h6000,           8, 0, 0,  0, -1, 1, 40'h6000, 0};
      vecs[8]  = '{"samebeat",  40'h5000,          20, 0, 0,  3,  3, 1, 40'h5030, 0};
      vecs[9]  = '{"rlast",     40'h5000,          20, 0, 0, -1,  7, 1, 40'h5070, 0};
      vecs[10] = '{"wrap",      40'hFF_FFFF_FFC0,   8, 1, 0, -1, -1, 0, 40'h0,    0};

      stall_en = 0; inj_b = 0; inj_r = -1; inj_l = -1;
      areset = 1; start = 0; base_addr = '0; num_beats = 16'd0;
      clear_logs();
      repeat (3) @(posedge aclk);
      #1;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset err_count", err_count, 16'd0);
      chk("reset awvalid", awvalid, 1'b0);
      chk("reset awaddr", awaddr, '0);
      chk("reset awlen", awlen, 8'd0);
      chk("reset wvalid", wvalid, 1'b0);
      chk("reset wdata", wdata, '0);
      chk("reset wlast", wlast, 1'b0);
      chk("reset arvalid", arvalid, 1'b0);
      chk("reset araddr", araddr, '0);
      chk("reset bready", bready, 1'b0);
      chk("reset rready", rready, 1'b0);
      areset = 0;
      @(posedge aclk); #1;

      for (int v = 0; v < 11; v++) begin
         run_test(vecs[v].name, vecs[v].base, vecs[v].n, vecs[v].st, vecs[v].ib,
                  vecs[v].ir, vecs[v].il, vecs[v].exp_err, vecs[v].first, vecs[v].poke);
      end

      for (int k = 0; k < 4; k++) begin
         logic [AW-1:0] rb;
         int            rn;
         rb = {8'($urandom), $urandom};
         rb[11:8] = 4'hF;
         rn = $urandom_range(1, 70);
         run_test($sformatf("rand%0d", k), rb, rn, 1'b1, 0, -1, -1, 0, '0, 1'b1);
      end

      // Reset in the middle of a write burst, with an error already counted.
      stall_en = 0; inj_b = 1; inj_r = -1; inj_l = -1;
      clear_logs();
      base_addr = 40'h9000; num_beats = 16'd40; start = 1;
      @(posedge aclk); #1;
      start = 0;
      cyc = 0;
      while (!(wvalid && err_count != 16'd0) && cyc < 500) begin
         @(posedge aclk); #1;
         cyc++;
      end
      chk("midreset reached W with error", wvalid && (err_count != 16'd0), 1'b1);
      areset = 1;
      @(posedge aclk); #1;
      chk("midreset awvalid", awvalid, 1'b0);
      chk("midreset wvalid", wvalid, 1'b0);
      chk("midreset arvalid", arvalid, 1'b0);
      chk("midreset bready", bready, 1'b0);
      chk("midreset rready", rready, 1'b0);
      chk("midreset busy", busy, 1'b0);
      chk("midreset done", done, 1'b0);
      chk("midreset err_count", err_count, 16'd0);
      areset = 0;
      @(posedge aclk); #1;
      run_test("after_reset", 40'h9000, 20, 1'b1, 0, -1, -1, 0, '0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
